// File: rtl/snn_input_loader.sv
// Unpacks a 1-bpp image arriving a byte at a time into the input-unit RAM, starts the
// classifier once the frame is complete, then transmits the resulting digit as ASCII.
`timescale 1ns/1ps
module snn_input_loader #(
    parameter int unsigned NUM_PIXELS = 784,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_rdy,
    input  logic [7:0]            rx_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_data,
    output logic                  ram_we,
    output logic                  snn_start,
    input  logic                  snn_done,
    input  logic [3:0]            snn_digit,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic [2:0] {
        StWaitByte,
        StUnpack,
        StStart,
        StWaitDone,
        StTx
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LastPix = ADDR_WIDTH'(NUM_PIXELS - 1);

    state_e                  state;
    logic [7:0]              sr;
    logic [7:0]              hb;
    logic                    hb_valid;
    logic [2:0]              bit_idx;
    logic [ADDR_WIDTH-1:0]   pix_cnt;
    logic [3:0]              digit;
    logic                    hb_take;

    assign hb_take = (state == StWaitByte) && hb_valid;
    assign busy    = !((state == StWaitByte) && (pix_cnt == '0));

    // RAM outputs are registered one step ahead so each write is visible in its own UNPACK cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StWaitByte;
            sr        <= '0;
            hb        <= '0;
            hb_valid  <= 1'b0;
            bit_idx   <= '0;
            pix_cnt   <= '0;
            digit     <= '0;
            ram_addr  <= '0;
            ram_data  <= 1'b0;
            ram_we    <= 1'b0;
            snn_start <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            overrun   <= 1'b0;
        end else begin
            ram_we    <= 1'b0;
            snn_start <= 1'b0;
            tx_start  <= 1'b0;

            // A byte arriving while the buffer is being drained is kept, not lost.
            if (rx_rdy) begin
                if (!hb_valid || hb_take) begin
                    hb <= rx_data;
                end else begin
                    overrun <= 1'b1;
                end
            end
            hb_valid <= rx_rdy || (hb_valid && !hb_take);

            unique case (state)
                StWaitByte: begin
                    if (hb_valid) begin
                        sr       <= {1'b0, hb[7:1]};
                        bit_idx  <= '0;
                        ram_we   <= 1'b1;
                        ram_addr <= pix_cnt;
                        ram_data <= hb[0];
                        state    <= StUnpack;
                    end
                end
                StUnpack: begin
                    sr      <= {1'b0, sr[7:1]};
                    pix_cnt <= pix_cnt + 1'b1;
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx != 3'd7) begin
                        ram_we   <= 1'b1;
                        ram_addr <= pix_cnt + 1'b1;
                        ram_data <= sr[0];
                    end else if (pix_cnt == LastPix) begin
                        snn_start <= 1'b1;
                        state     <= StStart;
                    end else begin
                        state <= StWaitByte;
                    end
                end
                StStart: begin
                    pix_cnt <= '0;
                    state   <= StWaitDone;
                end
                StWaitDone: begin
                    if (snn_done) begin
                        digit <= snn_digit;
                        state <= StTx;
                    end
                end
                StTx: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= 8'h30 + {4'h0, digit};
                        state    <= StWaitByte;
                    end
                end
                default: state <= StWaitByte;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_input_loader.sv
// Randomized bench for snn_input_loader: a queue of expected (address, pixel) writes is
// built from the bytes sent and compared against every RAM write the DUT makes.
`timescale 1ns/1ps
module tb_snn_input_loader;
    localparam int NPIX = 784;
    localparam int AW   = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_rdy = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic [AW-1:0] ram_addr;
    logic          ram_data;
    logic          ram_we;
    logic          snn_start;
    logic          snn_done = 1'b0;
    logic [3:0]    snn_digit = 4'h0;
    logic          tx_busy = 1'b0;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          busy;
    logic          overrun;

    snn_input_loader #(.NUM_PIXELS(NPIX), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_we    (ram_we),
        .snn_start (snn_start),
        .snn_done  (snn_done),
        .snn_digit (snn_digit),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: each sent byte becomes 8 pixel writes at consecutive frame addresses.
    int   exp_q[$];
    int   exp_pix = 0;
    int   frame_writes = 0;
    int   start_cnt = 0;
    int   we_cnt = 0;
    int   txs_cnt = 0;
    int   cyc = 0;
    int   last_write_cyc = -100;
    int   e;
    logic busy_prev = 1'b0;

    function automatic void push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back((exp_pix << 1) | int'(b[i]));
            exp_pix++;
            if (exp_pix == NPIX) exp_pix = 0;
        end
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (ram_we) begin
                we_cnt++;
                frame_writes++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ram_addr", 32'(ram_addr), 32'(e >> 1));
                    check("ram_data", 32'(ram_data), 32'(e & 1));
                end
                if (int'(ram_addr) == NPIX - 1) last_write_cyc = cyc;
            end
            if (snn_start) begin
                start_cnt++;
                check("start_latency", 32'(cyc - last_write_cyc), 32'd1);
                check("frame_len", 32'(frame_writes), 32'(NPIX));
                frame_writes = 0;
            end
            if (tx_start) begin
                txs_cnt++;
                check("tx_while_busy", 32'(busy_prev), 32'd0);
            end
        end
        busy_prev = tx_busy;
    end

    task automatic strobe(input logic [7:0] b);
        @(posedge clk); #1;
        rx_rdy = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rx_rdy = 1'b0;
    endtask

    task automatic send_spaced(input logic [7:0] b);
        push_byte(b);
        strobe(b);
        repeat (18) @(posedge clk);
    endtask

    task automatic wait_start(input int prev);
        int n = 0;
        while (start_cnt == prev && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("snn_start_seen", 32'(start_cnt), 32'(prev + 1));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_pix = 0;
        frame_writes = 0;
    endtask

    task automatic done_and_tx(input logic [3:0] d);
        @(posedge clk); #1;
        snn_done = 1'b1;
        snn_digit = d;
        @(posedge clk); #1;
        snn_done = 1'b0;
        snn_digit = 4'($urandom);
        check("tx_early", 32'(tx_start), 32'd0);
        @(posedge clk); #1;
        check("tx_latency", 32'(tx_start), 32'd1);
        check("tx_data", 32'(tx_data), 32'(8'h30 + {4'h0, d}));
        @(posedge clk); #1;
        check("tx_pulse_len", 32'(tx_start), 32'd0);
        check("busy_after_tx", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, s0, t0, n;
        logic [7:0] a, b;
        logic [3:0] d;

        // Reset with rx_rdy toggling
        repeat (2) begin
            @(posedge clk); #1;
            rx_rdy = ~rx_rdy;
            rx_data = 8'($urandom);
        end
        @(posedge clk); #1;
        rx_rdy = 1'b0;
        rst = 1'b0;
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_data", 32'(ram_data), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_snn_start", 32'(snn_start), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        w0 = we_cnt;
        repeat (20) @(posedge clk);
        check("idle_no_we", 32'(we_cnt - w0), 32'd0);

        // Frame of 8'hA5, then transmit held off by tx_busy
        s0 = start_cnt;
        for (int i = 0; i < NPIX / 8; i++) send_spaced(8'hA5);
        wait_start(s0);
        @(posedge clk); #1;
        check("busy_wait_done", 32'(busy), 32'd1);
        tx_busy = 1'b1;
        @(posedge clk); #1;
        snn_done = 1'b1;
        snn_digit = 4'd7;
        @(posedge clk); #1;
        snn_done = 1'b0;
        t0 = txs_cnt;
        repeat (5) @(posedge clk);
        check("tx_held_busy", 32'(txs_cnt - t0), 32'd0);
        check("busy_in_tx", 32'(busy), 32'd1);
        #1;
        tx_busy = 1'b0;
        n = 0;
        while (txs_cnt == t0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("tx_data_7", 32'(tx_data), 32'h37);
        check("busy_drop", 32'(busy), 32'd0);
        repeat (10) @(posedge clk);
        check("tx_once", 32'(txs_cnt - t0), 32'd1);
        check("overrun_a", 32'(overrun), 32'd0);

        // Back-to-back bytes FF, 00, then the rest of a random frame
        push_byte(8'hFF);
        push_byte(8'h00);
        @(posedge clk); #1;
        rx_rdy = 1'b1;
        rx_data = 8'hFF;
        @(posedge clk); #1;
        rx_data = 8'h00;
        @(posedge clk); #1;
        rx_rdy = 1'b0;
        repeat (30) @(posedge clk);
        check("overrun_b2b", 32'(overrun), 32'd0);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);
        s0 = start_cnt;
        for (int i = 0; i < NPIX / 8 - 2; i++) send_spaced(8'($urandom));
        wait_start(s0);
        d = 4'($urandom_range(0, 9));
        done_and_tx(d);

        // Partial frame, stray snn_done, then reset mid-frame
        t0 = txs_cnt;
        s0 = start_cnt;
        for (int i = 0; i < 40; i++) begin
            send_spaced(8'($urandom));
            if (i == 10) begin
                @(posedge clk); #1;
                snn_done = 1'b1;
                @(posedge clk); #1;
                snn_done = 1'b0;
            end
        end
        check("stray_done_ignored", 32'(txs_cnt - t0), 32'd0);
        do_reset();
        check("busy_after_rst", 32'(busy), 32'd0);
        for (int i = 0; i < NPIX / 8; i++) begin
            if (i == NPIX / 8 - 1) check("no_early_start", 32'(start_cnt), 32'(s0));
            send_spaced(8'($urandom));
        end
        wait_start(s0);
        d = 4'($urandom_range(0, 9));
        done_and_tx(d);

        // Three consecutive strobes: the third is dropped
        a = 8'($urandom);
        b = 8'($urandom);
        push_byte(a);
        push_byte(b);
        @(posedge clk); #1;
        rx_rdy = 1'b1;
        rx_data = a;
        @(posedge clk); #1;
        rx_data = b;
        @(posedge clk); #1;
        rx_data = 8'($urandom);
        @(posedge clk); #1;
        rx_rdy = 1'b0;
        repeat (30) @(posedge clk);
        check("overrun_set", 32'(overrun), 32'd1);
        send_spaced(8'($urandom));
        repeat (50) @(posedge clk);
        check("overrun_sticky", 32'(overrun), 32'd1);
        do_reset();
        check("overrun_cleared", 32'(overrun), 32'd0);
        repeat (20) @(posedge clk);
        check("leftover_writes", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
